// File: rtl/dense_fiber_scanner_pkg.sv
// Token encodings and FSM state codes shared by
// the dense fiber scanner and its output FIFOs.
package dense_fiber_scanner_pkg;

  localparam int DFS_DATA_W = 16;
  localparam int DONE_CODE  = 'h100;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FIBER = 2'd1;
  localparam state_t ST_LOOK  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // MSB of every stream token flags control (stop/Done)
  function automatic int tok_w(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/dense_fiber_scanner_reg_fifo.sv
// Small register FIFO with synchronous clear;
// data appears at dout the cycle after push.
module reg_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign valid   = (cnt != '0);
  assign dout    = mem[rp];
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      if (do_push && !do_pop)
        cnt <= cnt + CW'(1);
      else if (do_pop && !do_push)
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/dense_fiber_scanner.sv
// Expands position tokens into dense fibers of
// coord/pos tokens, emitted in lockstep.
module dense_fiber_scanner
  import dense_fiber_scanner_pkg::*;
#(
  parameter int DATA_W     = DFS_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic                         flush,
  input  logic                         tile_en,
  input  logic [DATA_W-1:0]            dim_size,
  input  logic [DATA_W-1:0]            inner_dim_offset,
  input  logic                         root,
  input  logic [tok_w(DATA_W)-1:0]     us_pos_in,
  input  logic                         us_pos_in_valid,
  output logic                         us_pos_in_ready,
  output logic [tok_w(DATA_W)-1:0]     coord_out,
  output logic                         coord_out_valid,
  input  logic                         coord_out_ready,
  output logic [tok_w(DATA_W)-1:0]     pos_out,
  output logic                         pos_out_valid,
  input  logic                         pos_out_ready,
  output logic                         done_pulse
);

  localparam int TW = tok_w(DATA_W);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);
  localparam logic [DATA_W-1:0] DONE_PL = DATA_W'(DONE_CODE);
  localparam logic [TW-1:0]     DN_TOK  = {1'b1, DONE_PL};
  localparam logic [TW-1:0]     S0_TOK  = {1'b1, {DATA_W{1'b0}}};

  state_t            state;
  logic [DATA_W-1:0] idx;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] dim_q;
  logic [DATA_W-1:0] off_q;
  logic              root_q;
  logic              done_owed;

  logic              c_full;
  logic              p_full;
  logic              c_nemp;
  logic              p_nemp;
  logic              adv;
  logic              in_fire;
  logic              push;
  logic              push_done;
  logic [TW-1:0]     tok_c;
  logic [TW-1:0]     tok_p;
  logic [TW-1:0]     look_tok;
  logic [DATA_W-1:0] in_pl;
  logic              in_ctrl;
  logic              in_done;
  logic [DATA_W-1:0] mul_p;
  logic [DATA_W-1:0] mul_d;
  logic [DATA_W-1:0] mul_o;
  logic [DATA_W-1:0] base_nxt;
  logic              idx_last;
  logic              is_idle;
  logic              is_fiber;
  logic              is_look;
  logic              is_done;

  assign is_idle  = (state == ST_IDLE);
  assign is_fiber = (state == ST_FIBER);
  assign is_look  = (state == ST_LOOK);
  assign is_done  = (state == ST_DONE);

  assign in_pl   = us_pos_in[DATA_W-1:0];
  assign in_ctrl = us_pos_in[DATA_W];
  assign in_done = in_ctrl && (in_pl == DONE_PL);

  assign adv = clk_en & tile_en & ~c_full & ~p_full;
  assign us_pos_in_ready = rst_n & adv &
    ((is_idle & ~root) | (is_look & ~root_q));
  assign in_fire = us_pos_in_valid & us_pos_in_ready;

  // Single shared multiplier: live config in IDLE, latched in LOOK
  assign mul_p    = (is_idle & root) ? '0 : in_pl;
  assign mul_d    = is_idle ? dim_size : dim_q;
  assign mul_o    = is_idle ? inner_dim_offset : off_q;
  assign base_nxt = mul_p * mul_d + mul_o;
  assign idx_last = ((idx + ONE) == dim_q);

  assign look_tok = (in_ctrl && !in_done) ?
    {1'b1, in_pl + ONE} : S0_TOK;

  always_comb begin
    push  = 1'b0;
    tok_c = '0;
    tok_p = '0;
    unique case (1'b1)
      is_idle: begin
        if (in_fire && in_ctrl) begin
          push  = 1'b1;
          tok_c = in_done ? DN_TOK : us_pos_in;
          tok_p = tok_c;
        end
      end
      is_fiber: begin
        if (adv && dim_q != '0) begin
          push  = 1'b1;
          tok_c = {1'b0, idx};
          tok_p = {1'b0, base + idx};
        end
      end
      is_look: begin
        if (adv && root_q) begin
          push  = 1'b1;
          tok_c = S0_TOK;
          tok_p = S0_TOK;
        end else if (in_fire) begin
          push  = 1'b1;
          tok_c = look_tok;
          tok_p = look_tok;
        end
      end
      is_done: begin
        if (adv && done_owed) begin
          push  = 1'b1;
          tok_c = DN_TOK;
          tok_p = DN_TOK;
        end
      end
    endcase
  end

  assign push_done = push && (tok_c == DN_TOK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      base       <= '0;
      dim_q      <= '0;
      off_q      <= '0;
      root_q     <= 1'b0;
      done_owed  <= 1'b0;
      done_pulse <= 1'b0;
    end else if (flush) begin
      state      <= ST_IDLE;
      idx        <= '0;
      base       <= '0;
      dim_q      <= '0;
      off_q      <= '0;
      root_q     <= 1'b0;
      done_owed  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= push_done;
      if (adv) begin
        unique case (1'b1)
          is_idle: begin
            if (root || (in_fire && !in_ctrl)) begin
              root_q <= root;
              dim_q  <= dim_size;
              off_q  <= inner_dim_offset;
              base   <= base_nxt;
              idx    <= '0;
              state  <= (dim_size == '0) ?
                        ST_LOOK : ST_FIBER;
            end else if (in_fire && in_done) begin
              state <= ST_DONE;
            end
          end
          is_fiber: begin
            if (dim_q == '0 || idx_last) begin
              idx   <= '0;
              state <= ST_LOOK;
            end else begin
              idx <= idx + ONE;
            end
          end
          is_look: begin
            if (root_q) begin
              done_owed <= 1'b1;
              state     <= ST_DONE;
            end else if (in_fire) begin
              if (!in_ctrl) begin
                base  <= base_nxt;
                idx   <= '0;
                state <= (dim_q == '0) ?
                         ST_LOOK : ST_FIBER;
              end else if (in_done) begin
                done_owed <= 1'b1;
                state     <= ST_DONE;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          is_done: begin
            if (done_owed)
              done_owed <= 1'b0;
            else if (!c_nemp && !p_nemp)
              state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  reg_fifo #(
    .WIDTH(TW),
    .DEPTH(FIFO_DEPTH)
  ) u_coord_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .din   (tok_c),
    .full  (c_full),
    .pop   (coord_out_ready & tile_en),
    .dout  (coord_out),
    .valid (c_nemp)
  );

  reg_fifo #(
    .WIDTH(TW),
    .DEPTH(FIFO_DEPTH)
  ) u_pos_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .din   (tok_p),
    .full  (p_full),
    .pop   (pos_out_ready & tile_en),
    .dout  (pos_out),
    .valid (p_nemp)
  );

  assign coord_out_valid = c_nemp & tile_en;
  assign pos_out_valid   = p_nemp & tile_en;

endmodule
